// File: rtl/pcs_lock_pkg.sv
// Shared definitions for the PCS block-lock logic: lock FSM states,
// default parameter values and the sync-header validity test.
package pcs_lock_pkg;

  typedef enum logic [1:0] {
    LOCK_INIT = 2'd0,
    TEST_SH   = 2'd1,
    SLIP      = 2'd2,
    SLIP_WAIT = 2'd3
  } lock_state_e;

  localparam int SH_WINDOW_DEF      = 64;
  localparam int INVALID_THRESH_DEF = 16;
  localparam int SLIP_WAIT_DEF      = 4;

  // A 66b sync header is legal only as 2'b01 or 2'b10.
  function automatic logic header_valid(input logic [1:0] header);
    return header[1] ^ header[0];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/block_lock_fsm.sv
// 64b/66b block-lock state machine: hunts for sync-header alignment by
// requesting gearbox bit slips, and counts locked-to-unlocked transitions.
module block_lock_fsm
  import pcs_lock_pkg::*;
#(
  parameter int SH_WINDOW      = SH_WINDOW_DEF,
  parameter int INVALID_THRESH = INVALID_THRESH_DEF,
  parameter int SLIP_WAIT      = SLIP_WAIT_DEF,
  parameter int LOSS_CNT_W     = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [1:0]            i_header,
  input  logic                  i_valid,
  output logic                  o_slip,
  output logic                  o_block_lock,
  output logic [LOSS_CNT_W-1:0] o_lock_loss_cnt
);

  localparam int CNT_W  = $clog2(SH_WINDOW + 1);
  localparam int WAIT_W = (SLIP_WAIT > 0) ? $clog2(SLIP_WAIT + 1) : 1;

  if ((INVALID_THRESH < 1) || (INVALID_THRESH > SH_WINDOW)) begin : g_bad_params
    $error("block_lock_fsm: INVALID_THRESH must lie in 1..SH_WINDOW");
  end

  // The parameter SLIP_WAIT hides the state literal of the same name, so
  // states are always referenced through the package scope.
  pcs_lock_pkg::lock_state_e state, state_nxt;
  logic [CNT_W-1:0]  sh_cnt, sh_cnt_nxt, sh_cnt_inc;
  logic [CNT_W-1:0]  inv_cnt, inv_cnt_nxt, inv_cnt_inc;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              lock_nxt;
  logic              loss_inc;
  logic              hdr_bad;

  assign hdr_bad     = !header_valid(i_header);
  assign sh_cnt_inc  = sh_cnt + 1'b1;
  assign inv_cnt_inc = inv_cnt + CNT_W'(hdr_bad);

  always_comb begin
    state_nxt    = state;
    sh_cnt_nxt   = sh_cnt;
    inv_cnt_nxt  = inv_cnt;
    wait_cnt_nxt = wait_cnt;
    lock_nxt     = o_block_lock;
    loss_inc     = 1'b0;
    case (state)
      pcs_lock_pkg::LOCK_INIT: begin
        sh_cnt_nxt  = '0;
        inv_cnt_nxt = '0;
        state_nxt   = pcs_lock_pkg::TEST_SH;
      end
      pcs_lock_pkg::TEST_SH: begin
        if (i_valid) begin
          sh_cnt_nxt  = sh_cnt_inc;
          inv_cnt_nxt = inv_cnt_inc;
          // Slip wins over a window end landing on the same header.
          if (hdr_bad && (!o_block_lock || (inv_cnt_inc == CNT_W'(INVALID_THRESH)))) begin
            state_nxt = pcs_lock_pkg::SLIP;
            lock_nxt  = 1'b0;
            loss_inc  = o_block_lock;
          end else if (sh_cnt_inc == CNT_W'(SH_WINDOW)) begin
            sh_cnt_nxt  = '0;
            inv_cnt_nxt = '0;
            if (inv_cnt_inc == '0) begin
              lock_nxt = 1'b1;
            end
          end
        end
      end
      pcs_lock_pkg::SLIP: begin
        sh_cnt_nxt   = '0;
        inv_cnt_nxt  = '0;
        wait_cnt_nxt = '0;
        state_nxt    = pcs_lock_pkg::SLIP_WAIT;
      end
      pcs_lock_pkg::SLIP_WAIT: begin
        if (SLIP_WAIT == 0) begin
          state_nxt = pcs_lock_pkg::TEST_SH;
        end else if (i_valid) begin
          if (wait_cnt == WAIT_W'(SLIP_WAIT - 1)) begin
            wait_cnt_nxt = '0;
            state_nxt    = pcs_lock_pkg::TEST_SH;
          end else begin
            wait_cnt_nxt = wait_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = pcs_lock_pkg::LOCK_INIT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= pcs_lock_pkg::LOCK_INIT;
      sh_cnt       <= '0;
      inv_cnt      <= '0;
      wait_cnt     <= '0;
      o_block_lock <= 1'b0;
      o_slip       <= 1'b0;
    end else begin
      state        <= state_nxt;
      sh_cnt       <= sh_cnt_nxt;
      inv_cnt      <= inv_cnt_nxt;
      wait_cnt     <= wait_cnt_nxt;
      o_block_lock <= lock_nxt;
      o_slip       <= (state == pcs_lock_pkg::SLIP);
    end
  end

  sat_counter #(.W(LOSS_CNT_W)) u_loss_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .inc     (loss_inc),
    .count   (o_lock_loss_cnt)
  );

endmodule

// File: tb/tb_block_lock_fsm.sv
// Bench for block_lock_fsm: two parameterisations share one stimulus stream and
// are checked every cycle against a behavioural model, plus directed scenarios.
module tb_block_lock_fsm;

  logic       i_clk    = 1'b0;
  logic       i_reset  = 1'b1;
  logic       i_valid  = 1'b0;
  logic [1:0] i_header = 2'b01;

  logic        slip0, lock0, slip1, lock1;
  logic [15:0] loss0;
  logic [1:0]  loss1;

  int n_cmp = 0;
  int n_bad = 0;

  // Per-instance parameters: [0] defaults, [1] small window with 2-bit loss counter
  int p_win[2]  = '{64, 8};
  int p_thr[2]  = '{16, 2};
  int p_wait[2] = '{4, 0};
  int p_lw[2]   = '{16, 2};

  // Model: pending-work flags and header bookkeeping, expected outputs
  bit m_init[2], m_slip[2], m_wait[2];
  int m_left[2], m_cnt[2], m_inv[2];
  bit e_lock[2], e_slip[2];
  int e_loss[2];
  logic [17:0] exp_q0[$];
  logic [17:0] exp_q1[$];
  logic [17:0] e0, e1;

  always #5 i_clk = ~i_clk;

  block_lock_fsm #(.SH_WINDOW(64), .INVALID_THRESH(16), .SLIP_WAIT(4), .LOSS_CNT_W(16)) u_dut0 (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_header        (i_header),
    .i_valid         (i_valid),
    .o_slip          (slip0),
    .o_block_lock    (lock0),
    .o_lock_loss_cnt (loss0)
  );

  block_lock_fsm #(.SH_WINDOW(8), .INVALID_THRESH(2), .SLIP_WAIT(0), .LOSS_CNT_W(2)) u_dut1 (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_header        (i_header),
    .i_valid         (i_valid),
    .o_slip          (slip1),
    .o_block_lock    (lock1),
    .o_lock_loss_cnt (loss1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [1:0] h);
    i_reset  = r;
    i_valid  = v;
    i_header = h;
    @(posedge i_clk);
    #1;
  endtask

  task automatic model_step(input int k);
    bit bad;
    if (i_reset) begin
      m_init[k] = 1'b1; m_slip[k] = 1'b0; m_wait[k] = 1'b0;
      m_left[k] = 0; m_cnt[k] = 0; m_inv[k] = 0;
      e_lock[k] = 1'b0; e_slip[k] = 1'b0; e_loss[k] = 0;
    end else begin
      e_slip[k] = m_slip[k];
      if (m_init[k]) begin
        m_init[k] = 1'b0;
        m_cnt[k] = 0; m_inv[k] = 0;
      end else if (m_slip[k]) begin
        m_slip[k] = 1'b0;
        m_wait[k] = 1'b1;
        m_left[k] = p_wait[k];
        m_cnt[k] = 0; m_inv[k] = 0;
      end else if (m_wait[k]) begin
        if (m_left[k] == 0) m_wait[k] = 1'b0;
        else if (i_valid) begin
          m_left[k]--;
          if (m_left[k] == 0) m_wait[k] = 1'b0;
        end
      end else if (i_valid) begin
        bad = (i_header == 2'b00) || (i_header == 2'b11);
        m_cnt[k]++;
        if (bad) m_inv[k]++;
        if (bad && (!e_lock[k] || m_inv[k] == p_thr[k])) begin
          m_slip[k] = 1'b1;
          if (e_lock[k]) begin
            e_lock[k] = 1'b0;
            if (e_loss[k] < (1 << p_lw[k]) - 1) e_loss[k]++;
          end
        end else if (m_cnt[k] == p_win[k]) begin
          if (m_inv[k] == 0) e_lock[k] = 1'b1;
          m_cnt[k] = 0; m_inv[k] = 0;
        end
      end
    end
  endtask

  always @(posedge i_clk) begin
    model_step(0);
    model_step(1);
    exp_q0.push_back({e_lock[0], e_slip[0], 16'(e_loss[0])});
    exp_q1.push_back({e_lock[1], e_slip[1], 16'(e_loss[1])});
  end

  always @(negedge i_clk) begin
    if (exp_q0.size() > 0 && exp_q1.size() > 0) begin
      e0 = exp_q0.pop_front();
      e1 = exp_q1.pop_front();
      chk("model_lock0", 32'(lock0), 32'(e0[17]));
      chk("model_slip0", 32'(slip0), 32'(e0[16]));
      chk("model_loss0", 32'(loss0), 32'(e0[15:0]));
      chk("model_lock1", 32'(lock1), 32'(e1[17]));
      chk("model_slip1", 32'(slip1), 32'(e1[16]));
      chk("model_loss1", 32'(loss1), 32'(e1[15:0]));
    end
  end

  initial begin
    int den;
    logic r, v, bad;
    logic [1:0] h;
    int dens[4] = '{1000, 64, 8, 3};

    // Reset values
    repeat (3) drive(1'b1, 1'b0, 2'b01);
    chk("rst_lock", 32'(lock0), 0);
    chk("rst_slip", 32'(slip0), 0);
    chk("rst_loss", 32'(loss0), 0);

    // Clean window locks one edge after the 64th header, no slip
    drive(1'b0, 1'b0, 2'b01);
    for (int i = 1; i <= 64; i++) begin
      drive(1'b0, 1'b1, 2'b01);
      chk("lock_no_slip", 32'(slip0), 0);
      if (i == 63) chk("lock_early", 32'(lock0), 0);
    end
    chk("lock_set", 32'(lock0), 1);

    // Locked: 15 invalid in a window keeps lock
    for (int i = 1; i <= 64; i++) drive(1'b0, 1'b1, (i <= 15) ? 2'b11 : 2'b10);
    chk("thr15_lock", 32'(lock0), 1);
    chk("thr15_loss", 32'(loss0), 0);

    // Locked: 16 invalid drops lock and pulses slip
    for (int i = 1; i <= 16; i++) begin
      drive(1'b0, 1'b1, 2'b00);
      if (i == 15) chk("thr16_still_locked", 32'(lock0), 1);
    end
    chk("thr16_unlock", 32'(lock0), 0);
    chk("thr16_loss", 32'(loss0), 1);
    drive(1'b0, 1'b0, 2'b01);
    chk("thr16_slip_pulse", 32'(slip0), 1);
    drive(1'b0, 1'b0, 2'b01);
    chk("thr16_slip_end", 32'(slip0), 0);

    // Unlocked: bad 3rd header, 4-7 discarded, counting restarts at 8th
    drive(1'b1, 1'b0, 2'b01);
    drive(1'b0, 1'b0, 2'b01);
    drive(1'b0, 1'b1, 2'b01);
    drive(1'b0, 1'b1, 2'b10);
    drive(1'b0, 1'b1, 2'b11);
    chk("hunt_slip_reg", 32'(slip0), 0);
    drive(1'b0, 1'b0, 2'b01);
    chk("hunt_slip_pulse", 32'(slip0), 1);
    for (int i = 4; i <= 7; i++) begin
      drive(1'b0, 1'b1, 2'b11);
      chk("hunt_discard", 32'(slip0), 0);
    end
    for (int i = 1; i <= 64; i++) begin
      drive(1'b0, 1'b1, 2'b01);
      if (i == 63) chk("hunt_lock_early", 32'(lock0), 0);
    end
    chk("hunt_lock", 32'(lock0), 1);

    // Locked: 16th invalid is also the 64th header -> slip wins
    for (int i = 1; i <= 64; i++) begin
      drive(1'b0, 1'b1, (i > 48) ? 2'b11 : 2'b10);
      if (i == 63) chk("coinc_locked", 32'(lock0), 1);
    end
    chk("coinc_unlock", 32'(lock0), 0);
    chk("coinc_loss", 32'(loss0), 1);
    drive(1'b0, 1'b0, 2'b01);
    chk("coinc_slip", 32'(slip0), 1);

    // Valid toggling 1/0: lock after 64 valid headers, idles change nothing
    drive(1'b1, 1'b0, 2'b01);
    drive(1'b0, 1'b0, 2'b01);
    for (int i = 1; i <= 64; i++) begin
      drive(1'b0, 1'b1, 2'b01);
      if (i < 64) chk("toggle_no_lock", 32'(lock0), 0);
      drive(1'b0, 1'b0, 2'b11);
      chk("toggle_idle_slip", 32'(slip0), 0);
    end
    chk("toggle_lock", 32'(lock0), 1);

    // Randomised traffic with varying error density
    for (int b = 0; b < 12; b++) begin
      den = dens[$urandom_range(0, 3)];
      for (int c = 0; c < 250; c++) begin
        r   = ($urandom_range(0, 499) == 0);
        v   = ($urandom_range(0, 3) != 0);
        bad = ($urandom_range(0, den - 1) == 0);
        if (bad) h = $urandom_range(0, 1) ? 2'b11 : 2'b00;
        else     h = $urandom_range(0, 1) ? 2'b10 : 2'b01;
        drive(r, v, h);
      end
    end

    // Small instance: 5 lock losses saturate a 2-bit counter at 3
    drive(1'b1, 1'b0, 2'b01);
    drive(1'b0, 1'b0, 2'b01);
    for (int n = 1; n <= 5; n++) begin
      for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 2'b01);
      chk("sat_lock", 32'(lock1), 1);
      drive(1'b0, 1'b1, 2'b11);
      drive(1'b0, 1'b1, 2'b00);
      chk("sat_unlock", 32'(lock1), 0);
      chk("sat_loss", 32'(loss1), (n < 3) ? n : 3);
      drive(1'b0, 1'b0, 2'b01);
      chk("sat_slip", 32'(slip1), 1);
      drive(1'b0, 1'b0, 2'b01);
    end

    // Default instance now sits in its discard phase; reset clears everything
    drive(1'b1, 1'b0, 2'b01);
    chk("rst_wait_lock0", 32'(lock0), 0);
    chk("rst_wait_slip0", 32'(slip0), 0);
    chk("rst_wait_loss0", 32'(loss0), 0);
    chk("rst_wait_lock1", 32'(lock1), 0);
    chk("rst_wait_slip1", 32'(slip1), 0);
    chk("rst_wait_loss1", 32'(loss1), 0);
    repeat (4) drive(1'b0, 1'b0, 2'b01);

    @(negedge i_clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
